gauss_blur3x3: RTL and testbench

Streaming 3x3 Gaussian smoother that sits directly downstream of the RGB-to-grayscale stage. It consumes that stage's `grayscale_o`/`done_o` pixel stream in raster order and buffers two previous rows. It emits one blurred pixel per interior window, with kernel [1 2 1; 2 4 2; 1 2 1]/16, for the feature-detection front end of the stitching pipeline.

---
 rtl/gauss_pkg.sv | 16 +
 rtl/gauss_line_buf.sv | 31 +++
 rtl/gauss_blur3x3.sv | 131 +++++++++++++
 tb/tb_gauss_blur3x3.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared constants for the 3x3 Gaussian smoother.
// Kernel weights, datapath widths and counter sizing.
package gauss_pkg;

  localparam int PIX_W    = 8;
  localparam int SUM_W    = 12;
  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTRE = 4;
  localparam int RND_OFS  = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// Two row memories (rows y-1 and y-2) sharing one column address.
// Reads are combinational, so they return the pre-write contents.
module gauss_line_buf
  import gauss_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rd0_o,
  output logic [PIX_W-1:0] rd1_o
);

  logic [PIX_W-1:0] lb0_mem [DEPTH];
  logic [PIX_W-1:0] lb1_mem [DEPTH];

  assign rd0_o = lb0_mem[addr_i];
  assign rd1_o = lb1_mem[addr_i];

  // Contents are never cleared; the y >= 2 rule masks stale rows.
  always_ff @(posedge clk) begin
    if (we_i) begin
      lb1_mem[addr_i] <= lb0_mem[addr_i];
      lb0_mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/gauss_blur3x3.sv
// Streaming 3x3 Gaussian smoother, 2-cycle latency, one output per window.
// Define GAUSS_ROUND_EN for round-half-up output instead of truncation.
module gauss_blur3x3
  import gauss_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] gray_i,
  input  logic             done_i,
  input  logic             sof_i,
  output logic [PIX_W-1:0] blur_o,
  output logic             done_o,
  output logic             eof_o
);

  localparam int XW = cnt_w(IMG_W);
  localparam int YW = cnt_w(IMG_H);

  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          x_last, y_last;

  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic             v1_q, v1_d, e1_q, e1_d;
  logic [SUM_W-1:0] sum_q, sum_d, rnd;
  logic             v2_q, v2_d, e2_q, e2_d;
  logic [PIX_W-1:0] blur_q, blur_d;
  logic             done_q, done_d, eof_q, eof_d;

  assign cur_x  = sof_i ? '0 : x_q;
  assign cur_y  = sof_i ? '0 : y_q;
  assign x_last = (cur_x == XW'(IMG_W - 1));
  assign y_last = (cur_y == YW'(IMG_H - 1));

  gauss_line_buf #(
    .DEPTH (IMG_W),
    .AW    (XW)
  ) u_lb (
    .clk     (clk),
    .we_i    (done_i),
    .addr_i  (cur_x),
    .wdata_i (gray_i),
    .rd0_o   (lb0_rd),
    .rd1_o   (lb1_rd)
  );

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    win_d = win_q;
    v1_d  = 1'b0;
    e1_d  = 1'b0;
    if (done_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = gray_i;
      v1_d = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
      e1_d = x_last && y_last;
    end
  end

  always_comb begin
    sum_d = SUM_W'(K_CORNER) * (SUM_W'(win_q[0][0]) + SUM_W'(win_q[0][2])
                              + SUM_W'(win_q[2][0]) + SUM_W'(win_q[2][2]))
          + SUM_W'(K_EDGE)   * (SUM_W'(win_q[0][1]) + SUM_W'(win_q[1][0])
                              + SUM_W'(win_q[1][2]) + SUM_W'(win_q[2][1]))
          + SUM_W'(K_CENTRE) * SUM_W'(win_q[1][1]);
    v2_d = v1_q;
    e2_d = e1_q;
  end

  always_comb begin
`ifdef GAUSS_ROUND_EN
    rnd = sum_q + SUM_W'(RND_OFS);
`else
    rnd = sum_q;
`endif
    blur_d = v2_q ? rnd[SUM_W-1 -: PIX_W] : blur_q;
    done_d = v2_q;
    eof_d  = v2_q && e2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      win_q  <= '0;
      v1_q   <= 1'b0;
      e1_q   <= 1'b0;
      sum_q  <= '0;
      v2_q   <= 1'b0;
      e2_q   <= 1'b0;
      blur_q <= '0;
      done_q <= 1'b0;
      eof_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      win_q  <= win_d;
      v1_q   <= v1_d;
      e1_q   <= e1_d;
      sum_q  <= sum_d;
      v2_q   <= v2_d;
      e2_q   <= e2_d;
      blur_q <= blur_d;
      done_q <= done_d;
      eof_q  <= eof_d;
    end
  end

  assign blur_o = blur_q;
  assign done_o = done_q;
  assign eof_o  = eof_q;

endmodule

// File: tb/tb_gauss_blur3x3.sv
// Scoreboard bench for gauss_blur3x3 on a 4x4 frame.
// Reference model keeps the frame as a 2-D image and convolves directly.
module tb_gauss_blur3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray_i;
  logic       done_i;
  logic       sof_i;
  logic [7:0] blur_o;
  logic       done_o;
  logic       eof_o;

  gauss_blur3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk    (clk),
    .rst    (rst),
    .gray_i (gray_i),
    .done_i (done_i),
    .sof_i  (sof_i),
    .blur_o (blur_o),
    .done_o (done_o),
    .eof_o  (eof_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int v;
    int e;
    int c;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int img [H][W];
  int mx = 0;
  int my = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ref_blur(input int cx, input int cy);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += img[cy - 2 + r][cx - 2 + c] * ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
`ifdef GAUSS_ROUND_EN
    return (s + 8) / 16;
`else
    return s / 16;
`endif
  endfunction

  // Model one accepted pixel; called in the cycle before the accepting edge.
  task automatic model_accept(input int pix, input bit sof);
    exp_t e;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = pix;
    if (mx >= 2 && my >= 2) begin
      e.v = ref_blur(mx, my);
      e.e = (mx == W - 1 && my == H - 1) ? 1 : 0;
      e.c = cyc + 3;
      q.push_back(e);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end
  endtask

  task automatic pix(input int p, input bit sof, input int gap);
    for (int i = 0; i < gap; i++) begin
      done_i = 1'b0;
      sof_i  = 1'($urandom_range(0, 1));
      gray_i = 8'($urandom);
      @(posedge clk);
      #1;
    end
    done_i = 1'b1;
    sof_i  = sof;
    gray_i = 8'(p);
    model_accept(p, sof);
    @(posedge clk);
    #1;
    done_i = 1'b0;
    sof_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q.delete();
    mx = 0;
    my = 0;
    #1;
    check("rst_done_now", int'(done_o), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_done_hold", int'(done_o), 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done_o) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("blur", int'(blur_o), e.v);
          check("eof", int'(eof_o), e.e);
          check("latency", cyc, e.c);
        end
      end else if (q.size() > 0 && cyc > q[0].c) begin
        e = q.pop_front();
        check("missing_out", cyc, e.c);
      end
    end
  end

  initial begin
    rst    = 1'b0;
    gray_i = '0;
    done_i = 1'b0;
    sof_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_blur", int'(blur_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_eof", int'(eof_o), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < W * H; i++) pix(100, 0, 0);
    for (int i = 0; i < W * H; i++) pix((i == W + 1) ? 255 : 0, 0, 0);
    for (int i = 0; i < W * H; i++) pix((i == W + 1) ? 255 : 0, 0, $urandom_range(0, 3));
    for (int i = 0; i < W * H; i++) pix(255, 0, 0);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < W * H; i++) pix($urandom_range(0, 255), 0, $urandom_range(0, 2));
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) pix($urandom_range(0, 255), 0, 0);
    do_reset();
    for (int i = 0; i < W * H; i++) pix(100, 0, 0);

    for (int i = 0; i < 6; i++) pix($urandom_range(0, 255), 0, 0);
    for (int i = 0; i < W * H; i++)
      pix($urandom_range(0, 255), (i == 0), $urandom_range(0, 3));
    for (int i = 0; i < W * H; i++) pix(255, (i == 0), 0);

    repeat (8) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
